// File: rtl/cluster_decoder1536.sv
// Rebuilds the 1536-pad valid map and per-pad counts from a frame of serial (adr, cnt) cluster words.
// Checks encoder ordering rules and detects start-of-frame markers that arrive mid-frame.
module cluster_decoder1536 #(
    parameter int unsigned     MXPADS     = 1536,
    parameter int unsigned     MXADRBITS  = 11,
    parameter int unsigned     MXCNTBITS  = 3,
    parameter int unsigned     MXCLUSTERS = 8,
    parameter logic [10:0]     NULL_ADR   = 11'h7FE
) (
    input  logic                          clock,
    input  logic                          global_reset,
    input  logic                          sof,
    input  logic [MXADRBITS-1:0]          adr,
    input  logic [MXCNTBITS-1:0]          cnt,
    output logic [MXPADS-1:0]             vpfs_out,
    output logic [MXPADS*MXCNTBITS-1:0]   cnts_out,
    output logic [3:0]                    nclusters,
    output logic                          out_valid,
    output logic                          order_err,
    output logic                          sync_err
);

    localparam int unsigned PW = (MXCLUSTERS > 1) ? $clog2(MXCLUSTERS) : 1;
    localparam int unsigned AW = MXADRBITS + 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(MXCLUSTERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [PW-1:0]                  phase_q, phase_d;
    logic [MXPADS-1:0]              vpf_acc_q, vpf_acc_d;
    logic [MXPADS*MXCNTBITS-1:0]    cnt_acc_q, cnt_acc_d;
    logic [3:0]                     ncl_acc_q, ncl_acc_d;
    logic                           err_acc_q, err_acc_d;
    logic [MXADRBITS-1:0]           prev_adr_q, prev_adr_d;
    logic                           have_prev_q, have_prev_d;
    logic                           seen_null_q, seen_null_d;

    logic [MXPADS-1:0]              vpfs_q, vpfs_d;
    logic [MXPADS*MXCNTBITS-1:0]    cnts_q, cnts_d;
    logic [3:0]                     ncl_q, ncl_d;
    logic                           out_valid_q, out_valid_d;
    logic                           order_err_q, order_err_d;
    logic                           sync_err_q, sync_err_d;

    logic                           take;
    logic [PW-1:0]                  cur_phase;
    logic [AW-1:0]                  adr_lo, adr_hi;
    logic                           adr_null, adr_in_map;

    always_comb begin
        take       = sof || (state_q == ACCUM);
        cur_phase  = sof ? '0 : phase_q;
        adr_lo     = {1'b0, adr};
        adr_hi     = adr_lo + AW'(cnt);
        adr_null   = (adr == MXADRBITS'(NULL_ADR));
        adr_in_map = (adr < MXADRBITS'(MXPADS));

        state_d     = state_q;
        phase_d     = phase_q;
        vpf_acc_d   = vpf_acc_q;
        cnt_acc_d   = cnt_acc_q;
        ncl_acc_d   = ncl_acc_q;
        err_acc_d   = err_acc_q;
        prev_adr_d  = prev_adr_q;
        have_prev_d = have_prev_q;
        seen_null_d = seen_null_q;
        vpfs_d      = vpfs_q;
        cnts_d      = cnts_q;
        ncl_d       = ncl_q;
        out_valid_d = 1'b0;
        order_err_d = order_err_q;
        sync_err_d  = 1'b0;

        if (take) begin
            // A sof always opens a fresh frame; inside ACCUM it also abandons the partial one.
            if (sof) begin
                vpf_acc_d   = '0;
                cnt_acc_d   = '0;
                ncl_acc_d   = '0;
                err_acc_d   = 1'b0;
                prev_adr_d  = '0;
                have_prev_d = 1'b0;
                seen_null_d = 1'b0;
                if (state_q == ACCUM) begin
                    sync_err_d = 1'b1;
                end
            end
            phase_d = cur_phase + PW'(1);
            state_d = ACCUM;

            if (adr_null) begin
                seen_null_d = 1'b1;
            end else if (adr_in_map) begin
                if ((have_prev_d && (adr <= prev_adr_d)) || seen_null_d) begin
                    err_acc_d = 1'b1;
                end
                prev_adr_d  = adr;
                have_prev_d = 1'b1;
                ncl_acc_d   = ncl_acc_d + 4'd1;
                // Pads past the top of the map simply fail the compare, so nothing wraps.
                for (int unsigned p = 0; p < MXPADS; p++) begin
                    if ((adr_lo <= AW'(p)) && (AW'(p) <= adr_hi)) begin
                        vpf_acc_d[p] = 1'b1;
                    end
                    if (adr_lo == AW'(p)) begin
                        cnt_acc_d[p*MXCNTBITS +: MXCNTBITS] = cnt;
                    end
                end
            end else begin
                err_acc_d = 1'b1;
            end

            if (cur_phase == LAST_PHASE) begin
                vpfs_d      = vpf_acc_d;
                cnts_d      = cnt_acc_d;
                ncl_d       = ncl_acc_d;
                order_err_d = err_acc_d;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            vpf_acc_q   <= '0;
            cnt_acc_q   <= '0;
            ncl_acc_q   <= '0;
            err_acc_q   <= 1'b0;
            prev_adr_q  <= '0;
            have_prev_q <= 1'b0;
            seen_null_q <= 1'b0;
            vpfs_q      <= '0;
            cnts_q      <= '0;
            ncl_q       <= '0;
            out_valid_q <= 1'b0;
            order_err_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            vpf_acc_q   <= vpf_acc_d;
            cnt_acc_q   <= cnt_acc_d;
            ncl_acc_q   <= ncl_acc_d;
            err_acc_q   <= err_acc_d;
            prev_adr_q  <= prev_adr_d;
            have_prev_q <= have_prev_d;
            seen_null_q <= seen_null_d;
            vpfs_q      <= vpfs_d;
            cnts_q      <= cnts_d;
            ncl_q       <= ncl_d;
            out_valid_q <= out_valid_d;
            order_err_q <= order_err_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign vpfs_out  = vpfs_q;
    assign cnts_out  = cnts_q;
    assign nclusters = ncl_q;
    assign out_valid = out_valid_q;
    assign order_err = order_err_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_cluster_decoder1536.sv
// Directed bench for cluster_decoder1536: inputs driven and outputs sampled on the falling edge.
module tb_cluster_decoder1536;

    localparam int unsigned MXPADS = 1536;
    localparam int unsigned CW     = 3;
    localparam int unsigned VW     = MXPADS * CW;
    localparam logic [10:0] NULL_ADR = 11'h7FE;

    logic               clock = 1'b0;
    logic               global_reset = 1'b0;
    logic               sof;
    logic [10:0]        adr;
    logic [2:0]         cnt;
    logic [MXPADS-1:0]  vpfs_out;
    logic [VW-1:0]      cnts_out;
    logic [3:0]         nclusters;
    logic               out_valid;
    logic               order_err;
    logic               sync_err;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned nv;
    int unsigned ns;

    logic [MXPADS-1:0]  ev;
    logic [VW-1:0]      ec;
    logic [10:0]        fa [8];
    logic [2:0]         fc [8];

    cluster_decoder1536 #(
        .MXPADS(1536), .MXADRBITS(11), .MXCNTBITS(3), .MXCLUSTERS(8), .NULL_ADR(11'h7FE)
    ) dut (
        .clock(clock), .global_reset(global_reset), .sof(sof), .adr(adr), .cnt(cnt),
        .vpfs_out(vpfs_out), .cnts_out(cnts_out), .nclusters(nclusters),
        .out_valid(out_valid), .order_err(order_err), .sync_err(sync_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        int unsigned idx;
        total++;
        assert (obs === exp) passed++;
        else begin
            idx = 0;
            for (int unsigned i = 0; i < VW; i++) begin
                if (obs[i] !== exp[i]) begin
                    idx = i;
                    break;
                end
            end
            $error("FAIL %s: first bad bit %0d observed %b expected %b", tag, idx, obs[idx], exp[idx]);
        end
    endtask

    task automatic drive(input logic s, input logic [10:0] a, input logic [2:0] c);
        @(negedge clock);
        sof = s;
        adr = a;
        cnt = c;
    endtask

    task automatic idle();
        drive(1'b0, NULL_ADR, 3'd0);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 8; i++) begin
            fa[i] = NULL_ADR;
            fc[i] = 3'd0;
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, fa[i], fc[i]);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] ncl, input logic err);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk_vec({tag, "_vpfs"}, VW'(vpfs_out), VW'(ev));
        chk_vec({tag, "_cnts"}, cnts_out, ec);
        chk({tag, "_ncl"}, 32'(nclusters), 32'(ncl));
        chk({tag, "_oerr"}, 32'(order_err), 32'(err));
    endtask

    initial begin
        sof = 1'b0;
        adr = NULL_ADR;
        cnt = 3'd0;
        #1 global_reset = 1'b1;
        #1;
        chk("rst_vpfs", 32'(vpfs_out == '0), 32'd1);
        chk("rst_cnts", 32'(cnts_out == '0), 32'd1);
        chk("rst_ncl", 32'(nclusters), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_errs", 32'({order_err, sync_err}), 32'd0);
        repeat (2) @(negedge clock);
        global_reset = 1'b0;
        idle();

        // Empty frame
        clear_frame();
        send_frame();
        chk("empty_latency", 32'(out_valid), 32'd0);
        idle();
        ev = '0; ec = '0;
        check_out("empty", 4'd0, 1'b0);
        idle();
        chk("empty_pulse", 32'(out_valid), 32'd0);

        // Single cluster
        clear_frame();
        fa[0] = 11'd100; fc[0] = 3'd3;
        send_frame();
        idle();
        ev = '0; ev[103:100] = '1;
        ec = '0; ec[100*CW +: CW] = 3'd3;
        check_out("single", 4'd1, 1'b0);
        idle();
        chk_vec("single_hold", VW'(vpfs_out), VW'(ev));

        // Low edge and truncation at the top of the map
        clear_frame();
        fa[0] = 11'd0;    fc[0] = 3'd0;
        fa[1] = 11'd1533; fc[1] = 3'd7;
        send_frame();
        idle();
        ev = '0; ev[0] = 1'b1; ev[1535:1533] = '1;
        ec = '0; ec[1533*CW +: CW] = 3'd7;
        check_out("edge", 4'd2, 1'b0);

        // Descending address and non-null after null
        clear_frame();
        fa[0] = 11'd500; fa[1] = 11'd200; fa[3] = 11'd900;
        send_frame();
        idle();
        ev = '0; ev[500] = 1'b1; ev[200] = 1'b1; ev[900] = 1'b1;
        ec = '0;
        check_out("order", 4'd3, 1'b1);
        idle();
        chk("order_sticky", 32'(order_err), 32'd1);

        // Repeated start pad: later cnt wins, still an ordering fault
        clear_frame();
        fa[0] = 11'd10; fc[0] = 3'd1;
        fa[1] = 11'd10; fc[1] = 3'd4;
        send_frame();
        idle();
        ev = '0; ev[14:10] = '1;
        ec = '0; ec[10*CW +: CW] = 3'd4;
        check_out("repeat", 4'd2, 1'b1);

        // Out-of-range, non-null address is dropped
        clear_frame();
        fa[0] = 11'd1700; fc[0] = 3'd2;
        send_frame();
        idle();
        ev = '0; ec = '0;
        check_out("oor", 4'd0, 1'b1);

        // Back-to-back frames
        clear_frame();
        fa[0] = 11'd5;
        send_frame();
        drive(1'b1, 11'd7, 3'd1);
        ev = '0; ev[5] = 1'b1; ec = '0;
        check_out("b2b_a", 4'd1, 1'b0);
        nv = 0;
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, NULL_ADR, 3'd0);
            nv += 32'(out_valid);
        end
        chk("b2b_gap", nv, 32'd0);
        idle();
        ev = '0; ev[8:7] = '1;
        ec = '0; ec[7*CW +: CW] = 3'd1;
        check_out("b2b_b", 4'd1, 1'b0);

        // sof at phase 4 aborts the partial frame
        nv = 0;
        drive(1'b1, 11'd20, 3'd0);
        nv += 32'(out_valid);
        for (int i = 1; i < 4; i++) begin
            idle();
            nv += 32'(out_valid);
        end
        drive(1'b1, 11'd30, 3'd0);
        nv += 32'(out_valid);
        idle();
        nv += 32'(out_valid);
        chk("resync_pulse", 32'(sync_err), 32'd1);
        ns = 0;
        for (int i = 2; i < 8; i++) begin
            idle();
            nv += 32'(out_valid);
            ns += 32'(sync_err);
        end
        chk("resync_no_valid", nv, 32'd0);
        chk("resync_pulse_width", ns, 32'd0);
        idle();
        ev = '0; ev[30] = 1'b1; ec = '0;
        check_out("resync", 4'd1, 1'b0);

        // Async reset at phase 3
        drive(1'b1, 11'd40, 3'd0);
        idle();
        idle();
        idle();
        #2 global_reset = 1'b1;
        #1;
        chk("arst_vpfs", 32'(vpfs_out == '0), 32'd1);
        chk("arst_ncl", 32'(nclusters), 32'd0);
        #1 global_reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            nv += 32'(out_valid);
        end
        chk("arst_no_valid", nv, 32'd0);
        clear_frame();
        fa[0] = 11'd60; fc[0] = 3'd2;
        send_frame();
        idle();
        ev = '0; ev[62:60] = '1;
        ec = '0; ec[60*CW +: CW] = 3'd2;
        check_out("post_rst", 4'd1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
